// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between mem_stage and the responder.
// Requests are level signals held until the one-cycle ready pulse.
interface dmem_responder_if;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        dmem_error;

    modport master (
        output dmem_addr, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
        input  dmem_rdata, dmem_ready, dmem_error
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
        output dmem_rdata, dmem_ready, dmem_error
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait-state latency,
// byte-lane writes, range checking and a one-cycle ready pulse.
module dmem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input logic               clk,
    input logic               reset,
    dmem_responder_if.slave   dmem
);

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [31:0] MEM_BYTES = 32'(4) << ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0][7:0] mem [DEPTH];

    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic                  acc_rd;
    logic                  acc_wr;
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  acc_err;
    logic                  commit;
    logic                  we;

    // With zero wait states the commit edge is also the sampling edge,
    // so the live request is used instead of the latched copy.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        acc_rd    = rd_q;
        acc_wr    = wr_q;
        if (state_q == IDLE) begin
            acc_addr  = dmem.dmem_addr;
            acc_wdata = dmem.dmem_wdata;
            acc_be    = dmem.dmem_byte_enable;
            acc_rd    = dmem.dmem_read;
            acc_wr    = dmem.dmem_write;
        end
        offset  = acc_addr - BASE_ADDR;
        idx     = offset[ADDR_WIDTH+1:2];
        acc_err = (acc_addr < BASE_ADDR) || (offset >= MEM_BYTES)
                  || (acc_rd && acc_wr);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dmem.dmem_read || dmem.dmem_write) begin
                    addr_d  = dmem.dmem_addr;
                    wdata_d = dmem.dmem_wdata;
                    be_d    = dmem.dmem_byte_enable;
                    rd_d    = dmem.dmem_read;
                    wr_d    = dmem.dmem_write;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        cnt_d   = WAIT_LD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d = acc_err;
            if (acc_err) begin
                rdata_d = 32'h0;
            end else if (acc_rd) begin
                rdata_d = mem[idx];
            end
        end
    end

    assign we = commit && !acc_err && acc_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; an aborted access never reaches commit.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && acc_be[b]) begin
                mem[idx][b] <= acc_wdata[8*b +: 8];
            end
        end
    end

    assign dmem.dmem_rdata = rdata_q;
    assign dmem.dmem_ready = (state_q == RESP);
    assign dmem.dmem_error = err_q;

endmodule
